// File: rtl/hap_cmp_sequencer.sv
// rtl/hap_cmp_sequencer.sv - fetch/decode/writeback sequencer around the combinational compare unit
module hap_cmp_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 3,
    parameter int IW     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [IW-1:0]     imem_data,
    output logic [4:0]        OPCODE,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    input  logic [DATA_W-1:0] RD,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              halted,
    output logic [7:0]        retired
);

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_LT   = 5'b01011;
    localparam logic [4:0] OP_GT   = 5'b01100;
    localparam logic [4:0] OP_EQ   = 5'b01101;
    localparam logic [4:0] OP_GTE  = 5'b01110;
    localparam logic [4:0] OP_LTE  = 5'b01111;
    localparam logic [4:0] OP_NE   = 5'b10000;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [IW-1:0]       ir;
    logic [DATA_W-1:0]   regfile [8];
    logic [DATA_W-1:0]   result;

    logic [4:0]          dec_op;
    logic [4:0]          ir_op;
    logic [2:0]          ir_rd;
    logic [2:0]          ir_rs1;
    logic [2:0]          ir_rs2;
    logic [DATA_W-1:0]   imm_ext;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_data;

    function automatic logic is_cmp(input logic [4:0] op);
        case (op)
            OP_LT, OP_GT, OP_EQ, OP_GTE, OP_LTE, OP_NE: is_cmp = 1'b1;
            default:                                    is_cmp = 1'b0;
        endcase
    endfunction

    // Decode happens straight off the memory word; later stages use the latched IR
    assign dec_op = imem_data[15:11];
    assign ir_op  = ir[15:11];
    assign ir_rd  = ir[10:8];
    assign ir_rs1 = ir[7:5];
    assign ir_rs2 = ir[4:2];

    assign imem_addr = pc;
    assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                       (state == S_EXEC)  || (state == S_WB);
    assign halted    = (state == S_HALTED);
    assign dbg_data  = regfile[dbg_sel];

    // Immediate is IR[2:0], zero-extended or truncated to the register width
    always_comb begin
        imm_ext = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < 3) begin
                imm_ext[i] = ir[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection; start only matters when not busy
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (dec_op == OP_HALT) begin
                    state_nxt = S_HALTED;
                end else if (is_cmp(dec_op)) begin
                    state_nxt = S_EXEC;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = S_FETCH;
            S_HALTED: if (start) state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Compare-unit drive: idle (all zero) everywhere except EXEC
    always_comb begin
        OPCODE = OP_NOP;
        R1     = '0;
        R2     = '0;
        if (state == S_EXEC) begin
            OPCODE = ir_op;
            R1     = regfile[ir_rs1];
            R2     = regfile[ir_rs2];
        end
    end

    // Writeback source: latched compare result or the LDI immediate; others write nothing
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        if (ir_op == OP_LDI) begin
            wr_en   = 1'b1;
            wr_data = imm_ext;
        end else if (is_cmp(ir_op)) begin
            wr_en   = 1'b1;
            wr_data = result;
        end
    end

    // PC, IR, result latch and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= '0;
            ir      <= '0;
            result  <= '0;
            retired <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc <= '0;
                    end
                end
                S_DECODE: begin
                    ir <= imem_data;
                    pc <= pc + ADDR_W'(1);
                end
                S_EXEC: begin
                    result <= RD;
                end
                S_WB: begin
                    retired <= retired + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Register file write in WB, after operands were sampled in EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regfile[i] <= '0;
            end
        end else if ((state == S_WB) && wr_en) begin
            regfile[ir_rd] <= wr_data;
        end
    end

endmodule
